mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req0  input  1  port 0 access request.
REQ-006 SHALL have port we0  input  1  port 0 access type: 1 = write, 0 = read.
REQ-007 SHALL have port addr0  input  ADDR_W  port 0 address.
REQ-008 SHALL have port wdata0  input  DATA_W  port 0 write data.
REQ-009 SHALL have port ack0  output  1  port 0 completion pulse.
REQ-010 SHALL have port rdata0  output  DATA_W  port 0 read data, valid while ack0=1.
REQ-011 SHALL have ports req1, we1, addr1, wdata1, ack1, rdata1, identical to port 0 for requester 1.
REQ-012 SHALL have port address  output  ADDR_W  data memory address.
REQ-013 SHALL have port write_data  output  DATA_W  data memory write data.
REQ-014 SHALL have port MemRead  output  1  data memory read enable.
REQ-015 SHALL have port MemWrite  output  1  data memory write enable; memory commits on the CLK rising edge.
REQ-016 SHALL have port read_data  input  DATA_W  data memory read data, combinational from address/MemRead.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have ports cnt0 and cnt1  output  8  completed-transaction counters per port.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-020 IDLE: when any req is high at edge k, SHALL latch the winner's index, we, addr and wdata, then enter ACCESS.
REQ-021 ACCESS: SHALL drive address/write_data from the latched values, and SHALL drive MemWrite=we or MemRead=~we for exactly one cycle.
REQ-022 At the end of ACCESS (edge k+1), SHALL register read_data into the winner's rdata (read only), then enter DONE.
REQ-023 DONE: SHALL assert the winner's ack for exactly one cycle (cycle k+2), then return to IDLE.
REQ-024 Latency: request sampled at edge k; ack high during cycle k+2; next grant no earlier than edge k+3.
REQ-025 Requesters SHALL hold req/we/addr/wdata until ack; the arbiter SHALL ignore input changes after latching.
REQ-026 If req drops after grant, SHALL complete the transaction and still pulse ack.
REQ-027 If req stays high through ack, SHALL treat it as a new request in IDLE.
REQ-028 Arbitration: round-robin with a last-granted pointer.
REQ-029 On simultaneous req0 and req1, SHALL grant the port not last granted.
REQ-030 A single requester SHALL always be granted.
REQ-031 Outside ACCESS, MemRead=MemWrite=0, address=0, write_data=0.
REQ-032 rdataN SHALL hold its last value until the next read for port N; write transactions SHALL not change rdataN.
REQ-033 cntN SHALL increment on every ackN and SHALL saturate at 255 (no wrap).
REQ-034 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-035 While RST=1, SHALL immediately force FSM=IDLE, all ack/MemRead/MemWrite/busy=0, address/write_data/rdata0/rdata1=0, cnt0/cnt1=0, last-granted pointer=port 1 (so port 0 wins the first tie).
REQ-036 RST asserted during ACCESS SHALL drop MemWrite before the next edge so no memory write occurs, and SHALL produce no ack.
REQ-037 On RST release, SHALL resume from IDLE at the first rising edge.

Verification
REQ-038 Single write: port 0 write addr=1, wdata=1 -> MemWrite high for one cycle with address=1; ack0 high two cycles after req sampling; cnt0=1.
REQ-039 Read-back: port 1 reads addr=1 after REQ-038 -> MemRead one cycle; rdata1=1 during ack1; rdata0 unchanged.
REQ-040 Contention: req0 and req1 rise together after reset, writing addr 2 (data 2) and addr 3 (data 3) -> port 0 acked first, port 1 acked three cycles later; reads of addr 2/3 return 2/3.
REQ-041 Fairness: both reqs held continuously for 6 transactions -> ack order 0,1,0,1,0,1; cnt0=cnt1=3; ack never concurrent.
REQ-042 Reset mid-access: RST asserted during ACCESS of a write of 0xDEAD to addr 5 -> no MemWrite edge, no ack, a later read of addr 5 returns its prior value, and counters are 0.
REQ-043 Saturation: 260 port-0 transactions -> cnt0 stays 255.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the two requester ports, the data-memory bus and the
//          status outputs of mem_arbiter into one interface.
// Ports (signals):
//   requester N (N=0,1): reqN, weN, addrN, wdataN -> arbiter; ackN, rdataN <- arbiter
//   memory bus: address, write_data, MemRead, MemWrite from arbiter; read_data to arbiter
//   status: busy, cnt0, cnt1 from arbiter
// Modports: slave = arbiter view, master = environment (requesters + memory) view.
`timescale 1ns/1ps

interface mem_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] read_data;

    logic              busy;
    logic [7:0]        cnt0;
    logic [7:0]        cnt1;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  read_data,
        output ack0, rdata0, ack1, rdata1,
        output address, write_data, MemRead, MemWrite,
        output busy, cnt0, cnt1
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output read_data,
        input  ack0, rdata0, ack1, rdata1,
        input  address, write_data, MemRead, MemWrite,
        input  busy, cnt0, cnt1
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: two-port round-robin arbiter in front of a single-ported data memory.
//          Each transaction takes IDLE -> ACCESS -> DONE: the request is latched
//          at edge k, the memory is driven for one cycle, and the winner's ack
//          pulses during cycle k+2.
// Ports:
//   CLK  - clock, all state changes on the rising edge
//   RST  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave: requester ports 0/1, memory bus, busy, cnt0/cnt1
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(255);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;     // port granted most recently
    logic              win_q, win_d;       // port owning the current transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;
    logic              busy_q, busy_d;
    logic              grant_c;            // winner of the current IDLE arbitration
    logic              sel_we_c;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        win_d        = win_q;
        we_d         = we_q;
        address_d    = '0;
        write_data_d = '0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        // On a tie the port that did not win last time gets the grant
        grant_c      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        sel_we_c     = grant_c ? bus.we1 : bus.we0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d      = ACCESS;
                    last_d       = grant_c;
                    win_d        = grant_c;
                    we_d         = sel_we_c;
                    address_d    = grant_c ? bus.addr1  : bus.addr0;
                    write_data_d = grant_c ? bus.wdata1 : bus.wdata0;
                    mem_write_d  = sel_we_c;
                    mem_read_d   = ~sel_we_c;
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (win_q) begin
                    ack1_d = 1'b1;
                    if (!we_q) rdata1_d = bus.read_data;
                    if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
                end else begin
                    ack0_d = 1'b1;
                    if (!we_q) rdata0_d = bus.read_data;
                    if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset clears MemWrite at once so an
    // interrupted write never reaches the memory edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            win_q        <= win_d;
            we_q         <= we_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.address    = address_q;
    assign bus.write_data = write_data_q;
    assign bus.MemRead    = mem_read_q;
    assign bus.MemWrite   = mem_write_q;
    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.rdata0     = rdata0_q;
    assign bus.rdata1     = rdata1_q;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter. A 16-word memory sits on the
//          memory bus; a transaction-level model (grant order, memory image,
//          per-port read data and saturating counters) predicts every cycle.
`timescale 1ns/1ps

module tb_mem_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Data memory: combinational read, write on the rising edge
    logic [DATA_W-1:0] mem [16] = '{default: '0};
    int                mem_writes = 0;

    always @(posedge CLK) begin
        if (bus.MemWrite) begin
            mem[bus.address[3:0]] <= bus.write_data;
            mem_writes            <= mem_writes + 1;
        end
    end

    assign bus.read_data = bus.MemRead ? mem[bus.address[3:0]] : '0;

    // Reference model
    logic [DATA_W-1:0] ref_mem [16] = '{default: '0};
    logic [DATA_W-1:0] ref_rdata [2];
    int                ref_cnt [2];
    bit                ref_last;

    // Per-port request payload
    bit                p_we [2];
    logic [ADDR_W-1:0] p_addr [2];
    logic [DATA_W-1:0] p_wdata [2];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Raise a request with the stored payload, or drop it and scramble the
    // payload so a late change would be visible if it leaked into the access
    task automatic drive(input int p, input bit r);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit                w;
        a = r ? p_addr[p]  : ADDR_W'($urandom);
        d = r ? p_wdata[p] : DATA_W'($urandom);
        w = r ? p_we[p]    : 1'($urandom);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic model_reset();
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        ref_cnt[0]   = 0;
        ref_cnt[1]   = 0;
        ref_last     = 1'b1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(0, 1'b0);
        drive(1, 1'b0);
        #1;
        model_reset();
        chk("rst_busy",  bus.busy, 0);
        chk("rst_acks",  {bus.ack0, bus.ack1}, 0);
        chk("rst_bus",   {bus.MemRead, bus.MemWrite, bus.address, bus.write_data}, 0);
        chk("rst_rdata", {bus.rdata0, bus.rdata1}, 0);
        chk("rst_cnt",   {bus.cnt0, bus.cnt1}, 0);
        step();
        step();
        RST = 1'b0;
    endtask

    // Issue requests on the ports in mask and check every cycle until the
    // transactions complete. Called #1 after a rising edge. With hold=1 the
    // requests stay up for nslots grants; early=1 drops the winner's request
    // right after it is granted.
    task automatic serve(input bit [1:0] mask, input bit hold, input int nslots, input bit early);
        bit [1:0]          pend;
        bit                win;
        bit                w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        pend = mask;
        if (mask[0]) drive(0, 1'b1);
        if (mask[1]) drive(1, 1'b1);
        step();
        for (int s = 0; s < nslots; s++) begin
            win      = (pend == 2'b11) ? ~ref_last : pend[1];
            ref_last = win;
            w        = p_we[win];
            a        = p_addr[win];
            d        = p_wdata[win];

            chk("acc_busy", bus.busy, 1);
            chk("acc_ctrl", {bus.MemWrite, bus.MemRead}, {w, ~w});
            chk("acc_addr", bus.address, a);
            if (w) chk("acc_wdata", bus.write_data, d);
            chk("acc_noack", {bus.ack0, bus.ack1}, 0);
            if (w) ref_mem[a[3:0]] = d;
            if (early && !hold) begin
                drive(int'(win), 1'b0);
                pend[win] = 1'b0;
            end
            step();

            if (!w) ref_rdata[win] = ref_mem[a[3:0]];
            if (ref_cnt[win] < 255) ref_cnt[win]++;
            chk("done_ack", {bus.ack0, bus.ack1}, {win == 1'b0, win == 1'b1});
            chk("done_rdata0", bus.rdata0, ref_rdata[0]);
            chk("done_rdata1", bus.rdata1, ref_rdata[1]);
            chk("done_cnt", {bus.cnt0, bus.cnt1}, {8'(ref_cnt[0]), 8'(ref_cnt[1])});
            chk("done_bus", {bus.MemRead, bus.MemWrite, bus.address, bus.write_data}, 0);
            chk("done_busy", bus.busy, 1);
            if (!hold) begin
                if (pend[win]) drive(int'(win), 1'b0);
                pend[win] = 1'b0;
            end else if (s == nslots - 1) begin
                drive(0, 1'b0);
                drive(1, 1'b0);
                pend = 2'b00;
            end
            step();

            chk("idle_busy", bus.busy, 0);
            chk("idle_bus", {bus.MemRead, bus.MemWrite, bus.address, bus.write_data}, 0);
            chk("idle_acks", {bus.ack0, bus.ack1}, 0);
            if (s < nslots - 1) step();
        end
    endtask

    task automatic set_port(input int p, input bit w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        p_we[p]    = w;
        p_addr[p]  = a;
        p_wdata[p] = d;
    endtask

    initial begin
        int w0;
        bit [1:0] m;
        drive(0, 1'b0);
        drive(1, 1'b0);
        model_reset();
        step();
        do_reset();

        // Single write, then read-back from the other port
        set_port(0, 1'b1, 1, 1);
        serve(2'b01, 1'b0, 1, 1'b0);
        chk("single_cnt0", bus.cnt0, 1);
        set_port(1, 1'b0, 1, 0);
        serve(2'b10, 1'b0, 1, 1'b0);
        chk("readback_rdata1", bus.rdata1, 1);
        chk("readback_rdata0", bus.rdata0, 0);

        // Contention straight after reset: port 0 first, port 1 three cycles later
        do_reset();
        set_port(0, 1'b1, 2, 2);
        set_port(1, 1'b1, 3, 3);
        serve(2'b11, 1'b0, 2, 1'b0);
        set_port(0, 1'b0, 2, 0);
        set_port(1, 1'b0, 3, 0);
        serve(2'b11, 1'b0, 2, 1'b0);
        chk("contend_rd2", bus.rdata0, 2);
        chk("contend_rd3", bus.rdata1, 3);

        // Fairness with both requests held for six grants
        do_reset();
        set_port(0, 1'b1, 6, 32'h600);
        set_port(1, 1'b1, 7, 32'h700);
        serve(2'b11, 1'b1, 6, 1'b0);
        chk("fair_cnt", {bus.cnt0, bus.cnt1}, {8'd3, 8'd3});

        // Reset in the middle of a write access
        set_port(0, 1'b1, 5, 32'h55);
        serve(2'b01, 1'b0, 1, 1'b0);
        set_port(0, 1'b1, 5, 32'hDEAD);
        drive(0, 1'b1);
        w0 = mem_writes;
        step();
        chk("midrst_pre_write", bus.MemWrite, 1);
        RST = 1'b1;
        #1;
        chk("midrst_write_drop", bus.MemWrite, 0);
        chk("midrst_busy", bus.busy, 0);
        drive(0, 1'b0);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            step();
            chk("midrst_noack", {bus.ack0, bus.ack1}, 0);
        end
        RST = 1'b0;
        chk("midrst_nowrite", mem_writes, w0);
        chk("midrst_cnt", {bus.cnt0, bus.cnt1}, 0);
        step();
        set_port(1, 1'b0, 5, 0);
        serve(2'b10, 1'b0, 1, 1'b0);
        chk("midrst_readback", bus.rdata1, 32'h55);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            m = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++)
                set_port(p, 1'($urandom), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
            serve(m, 1'b0, (m == 2'b11) ? 2 : 1, 1'($urandom));
        end

        // Counter saturation
        do_reset();
        for (int i = 0; i < 260; i++) begin
            set_port(0, 1'($urandom), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
            serve(2'b01, 1'b0, 1, 1'b0);
        end
        chk("sat_cnt0", bus.cnt0, 255);
        chk("sat_cnt1", bus.cnt1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
